// File: rtl/hs_pkg.sv
// Shared types and default sizes for the two-clock toggle handshake blocks.
package hs_pkg;

    // Default widths, used as parameter defaults by the handshake modules
    localparam int unsigned HS_DATA_W      = 8;
    localparam int unsigned HS_SYNC_STAGES = 2;
    localparam int unsigned HS_CNT_W       = 16;

    // Return-path sender states
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        IDLE     = 2'd1,
        WAIT_ACK = 2'd2
    } hs_resp_state_t;

endpackage

// File: rtl/hs_level_sync.sv
// N-flop level synchronizer with asynchronous active-low reset.
// Shared by the forward and return paths of the toggle handshake.
module hs_level_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous level through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hs_resp_sender.sv
// Return-path sender of the two-clock toggle handshake (clk_2 domain).
// Captures a slave response, toggles req_level and holds rsp_data_out until
// the far side's ack_level toggle comes back through the synchronizer.
// Optional macro HS_RESP_TIMEOUT_EN adds a sticky WAIT_ACK timeout flag.
module hs_resp_sender
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W      = HS_DATA_W,
    parameter int unsigned SYNC_STAGES = HS_SYNC_STAGES,
    parameter int unsigned CNT_W       = HS_CNT_W,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_2,
    input  logic              reset_2,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ready,
    output logic              req_level,
    output logic [DATA_W-1:0] rsp_data_out,
    input  logic              ack_level,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_count,
    output logic              proto_err,
    output logic              timeout_err
);

    // Reject configurations the handshake cannot work with
    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("hs_resp_sender: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    localparam int unsigned INIT_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES - 1);

    hs_resp_state_t    state;
    hs_resp_state_t    state_d;
    logic              ack_sync;
    logic [INIT_W-1:0] init_cnt;
    logic              accept;
    logic              done;
    logic              spurious;

    hs_level_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk_2),
        .rst_n (reset_2),
        .d     (ack_level),
        .q     (ack_sync)
    );

    // State register
    always_ff @(posedge clk_2 or negedge reset_2) begin
        if (!reset_2) begin
            state <= INIT;
        end else begin
            state <= state_d;
        end
    end

    // Next state and handshake decode; rsp_ready depends on registers only
    always_comb begin
        state_d   = state;
        rsp_ready = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        spurious  = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                spurious  = (ack_sync != req_level);
                rsp_ready = (ack_sync == req_level) && !proto_err;
                if (rsp_valid && rsp_ready) begin
                    accept  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req_level) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Datapath: init hold counter, captured data, request toggle and status
    always_ff @(posedge clk_2 or negedge reset_2) begin
        if (!reset_2) begin
            init_cnt     <= '0;
            req_level    <= 1'b0;
            rsp_data_out <= '0;
            busy         <= 1'b0;
            sent_count   <= '0;
            proto_err    <= 1'b0;
        end else begin
            if (state == INIT && init_cnt != INIT_LAST) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (accept) begin
                rsp_data_out <= rsp_data;
                req_level    <= ~req_level;
                busy         <= 1'b1;
            end
            if (done) begin
                busy       <= 1'b0;
                sent_count <= sent_count + 1'b1;
            end
            if (spurious) begin
                proto_err <= 1'b1;
            end
        end
    end

`ifdef HS_RESP_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wait_cnt;

    // Count WAIT_ACK cycles (saturating); flag sticks once TIMEOUT_CYC is hit
    always_ff @(posedge clk_2 or negedge reset_2) begin
        if (!reset_2) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == WAIT_ACK && wait_cnt != TO_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == WAIT_ACK && wait_cnt == TO_LAST) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/hs_resp_sender.md
Name: hs_resp_sender

Overview:
- Return-path sender of the two-clock handshake. It runs in the clk_2 (slave) domain and carries response bytes back to the clk_1 (master) domain.
- It uses the same toggle-level protocol as the forward path. A response is captured and req_level is toggled. The data is held stable until the far side's ack_level toggle has been synchronized back.
- It sits between the slave's response output and the far-domain return receiver.

Parameters:
- DATA_W, 8, width of the response data.
- SYNC_STAGES, 2, number of flops in the ack_level synchronizer (minimum 2).
- CNT_W, 16, width of the completed-transfer counter.
- TIMEOUT_CYC, 64, number of WAIT_ACK cycles before timeout_err is set (optional feature only).

Ports:
- clk_2  in  1  clk_2 domain clock.
- reset_2  in  1  asynchronous, active-low reset.
- rsp_valid  in  1  slave offers a response.
- rsp_data  in  DATA_W  response data, sampled on accept.
- rsp_ready  out  1  sender can accept a response this cycle.
- req_level  out  1  request toggle, sent to the far domain.
- rsp_data_out  out  DATA_W  held data, crosses to the far domain.
- ack_level  in  1  far-domain ack toggle, unsynchronized.
- busy  out  1  a transfer is outstanding.
- sent_count  out  CNT_W  number of completed transfers (wraps).
- proto_err  out  1  sticky flag: ack toggled with no request outstanding.
- timeout_err  out  1  sticky timeout flag (tied 0 without the macro).

Behaviour:
- Reset (reset_2 low, asynchronous):
  - state = INIT.
  - req_level, rsp_data_out, sent_count, busy, proto_err and timeout_err are all 0.
  - All synchronizer flops are cleared to 0.
  - rsp_ready = 0.
- ack_sync is ack_level passed through SYNC_STAGES flops; only ack_sync is used internally.
- INIT: hold for SYNC_STAGES cycles after reset release, then go to IDLE. rsp_ready = 0 throughout.
- IDLE:
  - rsp_ready = 1 iff ack_sync == req_level and proto_err == 0. rsp_ready is decoded from registers only, with no combinational path from rsp_valid.
  - Accept: on the edge where rsp_valid & rsp_ready, rsp_data_out <= rsp_data, req_level <= ~req_level, busy <= 1, state <= WAIT_ACK. req_level and data change on the same edge.
  - If ack_sync != req_level while in IDLE: proto_err <= 1 (sticky until reset) and rsp_ready stays 0.
- WAIT_ACK:
  - rsp_ready = 0.
  - rsp_data_out and req_level are held constant.
  - When ack_sync == req_level: state <= IDLE, busy <= 0, sent_count <= sent_count + 1 (modulo 2^CNT_W).
- Throughput: the earliest next accept is the cycle after the return to IDLE. There is no accept on the ack-detect edge.
- rsp_valid while rsp_ready = 0 is ignored; the slave holds rsp_valid and rsp_data until it sees ready.
- Reset mid-transfer: the block aborts to INIT with req_level = 0. The far side must also be reset; no recovery of the in-flight item.

Optional Feature:
- Macro: HS_RESP_TIMEOUT_EN.
- With the macro: a counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle. When it reaches TIMEOUT_CYC, timeout_err <= 1 (sticky until reset). The FSM keeps waiting, and a later ack still completes the transfer normally. The counter saturates.
- Without the macro: there is no counter, and timeout_err is tied to 0. The port list is identical in both builds.

Decomposition:
- Package hs_pkg holds:
  - hs_resp_state_t enum {INIT, IDLE, WAIT_ACK};
  - default DATA_W, SYNC_STAGES and CNT_W localparams.
- Sub-module hs_level_sync is an N-flop level synchronizer with async active-low reset, parameterized by SYNC_STAGES. It is reusable on the forward path.

Test Plan:
- Reset release: rsp_ready stays 0 for 2 cycles, then goes 1; req_level = 0; sent_count = 0.
- Single transfer: rsp_data = 8'hA5 accepted → req_level goes 1 and rsp_data_out = 8'hA5 on that edge. The bench toggles ack_level to 1 after 5 cycles → busy drops 2–3 cycles later, sent_count = 1.
- Hold check: rsp_data changes to 8'h3C during WAIT_ACK → rsp_data_out stays 8'hA5 and rsp_ready stays 0 until the ack is seen.
- Back-to-back: 4 items 1,2,3,4 with immediate bench acks → four req_level toggles, one accept per handshake, and no accept on any ack-detect edge; sent_count = 4.
- Spurious ack: toggle ack_level while IDLE → proto_err = 1, rsp_ready stays 0 until reset_2 is pulsed low.
- HS_RESP_TIMEOUT_EN, TIMEOUT_CYC = 8: no ack for 20 cycles → timeout_err = 1 at cycle 8. A late ack then completes the transfer with sent_count incrementing and timeout_err staying 1.
